// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide controller: widths, op codes and FSM states.
package md_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [2:0] MD_NOP   = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned radix-2 restoring divider core: one quotient bit per step, counter 0..DIV_ITERS-1.
module div_iter
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;

    // Remainder stays below the divisor, so the shifted value always fits in XLEN+1 bits.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign trial     = shifted - {1'b0, dvs_q};
    assign last      = (cnt_q == CNT_W'(DIV_ITERS - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!trial[XLEN]) begin
                rem_q <= trial[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/md_div_ctrl.sv
// HI/LO owner beside EXE: single-cycle MULT/MULTU/MTHI/MTLO, sequenced 32-step DIV/DIVU.
//
// state  | meaning
// IDLE   | no divide in flight; accepts any op
// PREP   | form operand magnitudes and result signs, load divider core
// ITER   | one restoring step per cycle for DIV_ITERS cycles
// FIX    | sign-correct quotient/remainder, write LO/HI
module md_div_ctrl
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [2:0]      issue_op,
    input  logic [XLEN-1:0] issue_a,
    input  logic [XLEN-1:0] issue_b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_t state, state_nxt;

    logic              accept;
    logic              is_div;
    logic              fix_wr;
    logic              iter_start;
    logic              iter_step;
    logic              iter_last;
    logic [XLEN-1:0]   a_lat, b_lat;
    logic              sgn_lat;
    logic              q_neg, r_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   quo, rem;
    logic [2*XLEN-1:0] prod_s, prod_u;

    assign accept = issue_valid && (state == S_IDLE) && !cancel;
    assign is_div = (issue_op == MD_DIV) || (issue_op == MD_DIVU);
    assign fix_wr = (state == S_FIX) && !cancel;
    assign busy   = (state != S_IDLE);

    assign a_mag = (sgn_lat && a_lat[XLEN-1]) ? (~a_lat + XLEN'(1)) : a_lat;
    assign b_mag = (sgn_lat && b_lat[XLEN-1]) ? (~b_lat + XLEN'(1)) : b_lat;

    // Sign-extended 64-bit operands give the exact signed product modulo 2^64.
    assign prod_s = {{XLEN{issue_a[XLEN-1]}}, issue_a} * {{XLEN{issue_b[XLEN-1]}}, issue_b};
    assign prod_u = {{XLEN{1'b0}}, issue_a} * {{XLEN{1'b0}}, issue_b};

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (iter_start),
        .step      (iter_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .last      (iter_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        iter_start = 1'b0;
        iter_step  = 1'b0;
        case (state)
            S_IDLE: if (accept && is_div) state_nxt = S_PREP;
            S_PREP: begin
                iter_start = 1'b1;
                state_nxt  = S_ITER;
            end
            S_ITER: begin
                iter_step = 1'b1;
                if (iter_last) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cancel && (state != S_IDLE)) begin
            state_nxt  = S_IDLE;
            iter_start = 1'b0;
            iter_step  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat   <= '0;
            b_lat   <= '0;
            sgn_lat <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= fix_wr;
            if (accept && is_div) begin
                a_lat   <= issue_a;
                b_lat   <= issue_b;
                sgn_lat <= (issue_op == MD_DIV);
            end
            if (state == S_PREP) begin
                q_neg <= sgn_lat && (a_lat[XLEN-1] ^ b_lat[XLEN-1]);
                r_neg <= sgn_lat && a_lat[XLEN-1];
            end
            if (fix_wr) begin
                // Divide by zero reports the raw dividend, bypassing sign correction.
                if (b_lat == '0) begin
                    lo <= '1;
                    hi <= a_lat;
                end else begin
                    lo <= q_neg ? (~quo + XLEN'(1)) : quo;
                    hi <= r_neg ? (~rem + XLEN'(1)) : rem;
                end
            end else if (accept) begin
                case (issue_op)
                    MD_MULT: begin
                        hi <= prod_s[2*XLEN-1:XLEN];
                        lo <= prod_s[XLEN-1:0];
                    end
                    MD_MULTU: begin
                        hi <= prod_u[2*XLEN-1:XLEN];
                        lo <= prod_u[XLEN-1:0];
                    end
                    MD_MTHI: hi <= issue_a;
                    MD_MTLO: lo <= issue_a;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/md_div_ctrl.md
# md_div_ctrl

Multiply/divide controller that owns the HI/LO register pair and sequences a 32-iteration radix-2 divider for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Sits beside the EXE stage of the 5-stage pipeline. Its `busy` output is the `DIV_Busy` input of the bypass/stall unit, which stalls ID while a divide is in flight. It also aborts in-flight divides on exception/interrupt entry.

## Interface
- `XLEN`, 32: operand and HI/LO width.
- `DIV_ITERS`, 32: divider iteration count; must equal `XLEN`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  EXE-stage instruction valid and writes HI/LO.
- `issue_op`  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
- `issue_a`  in  XLEN  rs value (dividend / multiplicand / MTHI/MTLO data).
- `issue_b`  in  XLEN  rt value (divisor / multiplier).
- `cancel`  in  1  exception/interrupt handling (`ex_int_handle`); kills in-flight divide.
- `busy`  out  1  divide in flight; drives `DIV_Busy`.
- `done`  out  1  one-cycle pulse: divide result written to HI/LO.
- `hi`  out  XLEN  HI register.
- `lo`  out  XLEN  LO register.

## Operation
- States: IDLE, PREP, ITER, FIX. `busy` = (state != IDLE), decoded from registered state.
- Accept = issue_valid & state==IDLE & ~cancel. Issue while busy or with cancel high is dropped, with no side effect. Decode drives the bypass unit's `DIV` input for every HI/LO-touching op, so ID stalls these ops while busy.
- MULT/MULTU accepted: full 2·XLEN product (signed/unsigned), combinational from operands. HI←product[63:32], LO←product[31:0] at the accept edge. State stays IDLE; `busy` never rises.
- MTHI/MTLO accepted: `hi`/`lo` ← issue_a at the accept edge; the other register is unchanged.
- DIV/DIVU accepted: latch operands and signedness → PREP.
- PREP: form |a|, |b| (signed) or raw (unsigned). Record q_neg = sign(a)^sign(b) and r_neg = sign(a). Clear the iteration counter → ITER.
- ITER: one restoring step per cycle (shift remainder:quotient left 1, trial subtract, set quotient bit). After `DIV_ITERS` cycles (counter 0..31) → FIX.
- FIX: apply two's-complement negation to the quotient if q_neg and to the remainder if r_neg. LO←quotient, HI←remainder at the edge leaving FIX → IDLE. `done`=1 for the following cycle.
- Divide by zero, either signedness: LO=32'hFFFFFFFF, HI=issue_a unchanged (sign fix bypassed).
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of the algorithm, with no trap.
- Cancel while state≠IDLE (including FIX): next state IDLE, HI/LO unchanged, no `done`.
- rst: state IDLE, counter 0, `hi`=`lo`=0, `busy`=0, `done`=0, latched operands 0.

## Timing
- MULT/MULTU/MTHI/MTLO: result visible in `hi`/`lo` the cycle after the accept edge (latency 1). Back-to-back issue every cycle is allowed.
- DIV/DIVU, accept at edge E0:
  - `busy` high cycles E0+1 … E0+34 (PREP 1, ITER 32, FIX 1).
  - HI/LO updated at edge E0+34.
  - `done` high in cycle E0+35 (after edge E0+34), coincident with `busy`=0.
  - A new op is acceptable in that same cycle.
- Cancel is sampled every cycle. Abort takes effect at the next edge; `busy` low one cycle after `cancel` is seen.
- No combinational path from inputs to `busy`/`done`/`hi`/`lo`.

## Structure
- Package `md_pkg`: `XLEN`, op encodings (`MD_NOP`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`), state encoding (`S_IDLE`, `S_PREP`, `S_ITER`, `S_FIX`).
- Sub-module `div_iter`: unsigned restoring core holding the remainder/quotient shift registers and counter. Inputs are start/step controls; outputs are quotient, remainder and last-iteration flag.
- FSM, sign handling, multiplier, HI/LO and cancel logic live in `md_div_ctrl`.

## Test plan
- MULT a=0xFFFFFFFF b=2 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE; `busy` stays 0. MULTU same operands → HI=1, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9) b=2 → `busy` high exactly 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; `done` one cycle. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV 9/3. Assert `cancel` at ITER count 10 → `busy` 0 next cycle, HI=0x11, LO=0x22, no `done`. DIVU 9/3 issued next cycle completes with LO=3, HI=0.
- MULT issued while `busy` → ignored; HI/LO hold the divide result at completion. Issue with `cancel`=1 in IDLE → ignored.
- Assert `rst` mid-ITER → next cycle `busy`=0, `hi`=`lo`=0, `done`=0; a fresh DIVU 10/3 then gives LO=3, HI=1.
